// File: rtl/mt_fetch_sched.sv
// Multi-threaded instruction fetch scheduler.
// Keeps one PC per hardware thread and picks threads round-robin, at most
// one fetch per clock. The word at the selected PC is captured into a
// single fetch register. Redirects overwrite a thread's PC and can squash
// a held instruction from that thread while the pipe is stalled.
module mt_fetch_sched #(
  parameter int NT    = 4,
  parameter int Psize = 512,
  parameter int n     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NT-1:0]         thread_en,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [$clog2(NT)-1:0] redirect_tid,
  input  logic [n-1:0]          redirect_pc,
  output logic [n-1:0]          imem_addr,
  input  logic [n-1:0]          imem_rdata,
  output logic                  if_valid,
  output logic [$clog2(NT)-1:0] if_tid,
  output logic [n-1:0]          if_pc,
  output logic [n-1:0]          if_instr
);
  localparam int TW = $clog2(NT);
  // Psize is a power of two, so Psize-4 keeps exactly the word-aligned
  // in-range bits: one AND both wraps mod Psize and clears bits [1:0].
  localparam logic [n-1:0] AMASK = n'(Psize - 4);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [NT-1:0][n-1:0] pc_q;
  logic [TW-1:0]        last_q;
  logic [TW-1:0]        sel, idx;
  logic [NT-1:0]        elig;
  logic                 any_elig, found, fetch, squash;
  logic                 if_valid_q;
  logic [TW-1:0]        if_tid_q;
  logic [n-1:0]         if_pc_q, if_instr_q;

  // A thread being redirected this cycle sits out, so its new PC is used
  // no earlier than the following cycle.
  always_comb begin
    for (int t = 0; t < NT; t++)
      elig[t] = thread_en[t] && !(redirect_valid && (redirect_tid == TW'(t)));
  end

  assign any_elig = |elig;

  // Round-robin pick: first eligible thread strictly after last_q.
  // The k == NT step wraps back onto last_q itself, giving it lowest priority.
  always_comb begin
    sel   = last_q;
    idx   = last_q;
    found = 1'b0;
    for (int k = 1; k <= NT; k++) begin
      idx = last_q + TW'(k);
      if (!found && elig[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: stall wins, otherwise run whenever someone can fetch.
  always_comb begin
    state_d = state_q;
    if (stall)         state_d = HOLD;
    else if (any_elig) state_d = RUN;
    else               state_d = IDLE;
  end

  // FSM outputs: a fetch happens exactly on the edges that enter RUN.
  always_comb begin
    fetch     = (state_d == RUN);
    imem_addr = fetch ? pc_q[sel] : pc_q[last_q];
    squash    = stall && redirect_valid && if_valid_q && (if_tid_q == redirect_tid);
  end

  // Fetch register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      if_valid_q <= 1'b0;
      if_tid_q   <= '0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      last_q     <= TW'(NT - 1);
    end else if (fetch) begin
      if_valid_q <= 1'b1;
      if_tid_q   <= sel;
      if_pc_q    <= pc_q[sel];
      if_instr_q <= imem_rdata;
      last_q     <= sel;
    end else if (!stall || squash) begin
      if_valid_q <= 1'b0;
    end
  end

  // Per-thread PCs. The fetched thread is never the redirected one, so
  // the two updates cannot collide on the same entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int t = 0; t < NT; t++) pc_q[t] <= n'(t * (Psize / NT));
    end else begin
      for (int t = 0; t < NT; t++) begin
        if (redirect_valid && (redirect_tid == TW'(t)))
          pc_q[t] <= redirect_pc & AMASK;
        else if (fetch && (sel == TW'(t)))
          pc_q[t] <= (pc_q[t] + n'(4)) & AMASK;
      end
    end
  end

  assign if_valid = if_valid_q;
  assign if_tid   = if_tid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

endmodule
